// File: rtl/rgb_to_ycbcr_stream.sv
// Four-stage BT.601 RGB -> YCbCr converter with valid/ready streaming, optional studio-range
// scaling and a user sideband that travels with each pixel.
module rgb_to_ycbcr_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned USER_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_g,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_studio,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic [DATA_W-1:0] out_cb,
    output logic [DATA_W-1:0] out_cr,
    output logic [USER_W-1:0] out_user
);

    localparam int unsigned ONE = 1 << FRAC_W;
    localparam int unsigned KR  = (299 * ONE + 500) / 1000;
    localparam int unsigned KB  = (114 * ONE + 500) / 1000;
    localparam int unsigned KG  = ONE - KR - KB;
    localparam int unsigned KCB = (564 * ONE + 500) / 1000;
    localparam int unsigned KCR = (713 * ONE + 500) / 1000;
    localparam int unsigned PW  = DATA_W + FRAC_W;
    localparam int unsigned SW  = PW + 2;
    localparam int unsigned CW  = DATA_W + FRAC_W + 12;

    // One generous signed width for all chroma and studio arithmetic.
    typedef logic signed [CW-1:0] wide_t;

    localparam wide_t RND_C  = wide_t'(ONE / 2);
    localparam wide_t HALF_C = wide_t'(1 << (DATA_W - 1));
    localparam wide_t MAX_C  = wide_t'((1 << DATA_W) - 1);
    localparam wide_t YOFF_C = wide_t'(16 << (DATA_W - 8));
    localparam wide_t KCB_C  = wide_t'(KCB);
    localparam wide_t KCR_C  = wide_t'(KCR);
    localparam wide_t K220_C = wide_t'(220);
    localparam wide_t K225_C = wide_t'(225);
    localparam wide_t R128_C = wide_t'(128);

    function automatic logic [DATA_W-1:0] clamp(input wide_t v);
        if (v < 0) return '0;
        if (v > MAX_C) return '1;
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] chroma(input logic signed [DATA_W:0] d, input wide_t k);
        wide_t p;
        p = (wide_t'(d) * k + RND_C) >>> FRAC_W;
        return clamp(HALF_C + p);
    endfunction

    function automatic logic [DATA_W-1:0] studio_y(input logic [DATA_W-1:0] y);
        wide_t p;
        p = (wide_t'(y) * K220_C + R128_C) >>> 8;
        return clamp(YOFF_C + p);
    endfunction

    function automatic logic [DATA_W-1:0] studio_c(input logic [DATA_W-1:0] c);
        wide_t p;
        p = ((wide_t'(c) - HALF_C) * K225_C + R128_C) >>> 8;
        return clamp(HALF_C + p);
    endfunction

    logic                     en;
    logic                     v1_q, v2_q, v3_q;
    logic [PW-1:0]            pr_q, pg_q, pb_q;
    logic [DATA_W-1:0]        r1_q, b1_q;
    logic                     s1_q, s2_q, s3_q;
    logic [USER_W-1:0]        u1_q, u2_q, u3_q;
    logic [DATA_W-1:0]        y2_q, y3_q, cb3_q, cr3_q;
    logic signed [DATA_W:0]   db2_q, dr2_q;

    logic [SW-1:0]            sum_c;
    logic [DATA_W-1:0]        y_c;
    logic signed [DATA_W:0]   db_c, dr_c;
    logic [DATA_W-1:0]        y4_c, cb4_c, cr4_c;

    // Whole pipeline freezes while the output register is full and not taken.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign sum_c = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + SW'(ONE / 2);
    assign y_c   = DATA_W'(sum_c >> FRAC_W);
    assign db_c  = $signed({1'b0, b1_q}) - $signed({1'b0, y_c});
    assign dr_c  = $signed({1'b0, r1_q}) - $signed({1'b0, y_c});

    always_comb begin
        y4_c  = y3_q;
        cb4_c = cb3_q;
        cr4_c = cr3_q;
        if (s3_q) begin
            y4_c  = studio_y(y3_q);
            cb4_c = studio_c(cb3_q);
            cr4_c = studio_c(cr3_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            out_valid <= 1'b0;
            pr_q      <= '0;
            pg_q      <= '0;
            pb_q      <= '0;
            r1_q      <= '0;
            b1_q      <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            u1_q      <= '0;
            u2_q      <= '0;
            u3_q      <= '0;
            y2_q      <= '0;
            db2_q     <= '0;
            dr2_q     <= '0;
            y3_q      <= '0;
            cb3_q     <= '0;
            cr3_q     <= '0;
            out_y     <= '0;
            out_cb    <= '0;
            out_cr    <= '0;
            out_user  <= '0;
        end else if (en) begin
            v1_q      <= in_valid;
            pr_q      <= PW'(in_r) * PW'(KR);
            pg_q      <= PW'(in_g) * PW'(KG);
            pb_q      <= PW'(in_b) * PW'(KB);
            r1_q      <= in_r;
            b1_q      <= in_b;
            s1_q      <= in_studio;
            u1_q      <= in_user;

            v2_q      <= v1_q;
            y2_q      <= y_c;
            db2_q     <= db_c;
            dr2_q     <= dr_c;
            s2_q      <= s1_q;
            u2_q      <= u1_q;

            v3_q      <= v2_q;
            y3_q      <= y2_q;
            cb3_q     <= chroma(db2_q, KCB_C);
            cr3_q     <= chroma(dr2_q, KCR_C);
            s3_q      <= s2_q;
            u3_q      <= u2_q;

            out_valid <= v3_q;
            out_y     <= y4_c;
            out_cb    <= cb4_c;
            out_cr    <= cr4_c;
            out_user  <= u3_q;
        end
    end

endmodule

// File: tb/tb_rgb_to_ycbcr_stream.sv
// Scoreboard bench for rgb_to_ycbcr_stream: directed colour vectors, a random stalled stream
// and a mid-flight reset, all checked against an arithmetic BT.601 model.
module tb_rgb_to_ycbcr_stream;
    localparam int W = 8;
    localparam int F = 8;
    localparam int U = 2;

    localparam int SC  = 1 << F;
    localparam int KR  = (299 * SC + 500) / 1000;
    localparam int KB  = (114 * SC + 500) / 1000;
    localparam int KG  = SC - KR - KB;
    localparam int KCB = (564 * SC + 500) / 1000;
    localparam int KCR = (713 * SC + 500) / 1000;

    typedef logic [3*W+U-1:0] exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic         in_studio = 1'b0;
    logic [U-1:0] in_user = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_y, out_cb, out_cr;
    logic [U-1:0] out_user;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    bit   rand_ready = 1'b0;

    rgb_to_ycbcr_stream #(.DATA_W(W), .FRAC_W(F), .USER_W(U)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_r     (in_r),
        .in_g     (in_g),
        .in_b     (in_b),
        .in_studio(in_studio),
        .in_user  (in_user),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .out_cb   (out_cb),
        .out_cr   (out_cr),
        .out_user (out_user)
    );

    always #5 clk = ~clk;

    function automatic int fdiv(int a, int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int clip(int v);
        if (v < 0) return 0;
        if (v > (1 << W) - 1) return (1 << W) - 1;
        return v;
    endfunction

    function automatic exp_t model(int r, int g, int b, bit st, logic [U-1:0] u);
        int half, y, cb, cr;
        half = 1 << (W - 1);
        y  = fdiv(r * KR + g * KG + b * KB + SC / 2, SC);
        cb = clip(half + fdiv((b - y) * KCB + SC / 2, SC));
        cr = clip(half + fdiv((r - y) * KCR + SC / 2, SC));
        if (st) begin
            y  = clip((16 << (W - 8)) + fdiv(y * 220 + 128, 256));
            cb = clip(half + fdiv((cb - half) * 225 + 128, 256));
            cr = clip(half + fdiv((cr - half) * 225 + 128, 256));
        end
        return {W'(y), W'(cb), W'(cr), u};
    endfunction

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pop on every output transfer, and check outputs hold across stalls.
    initial begin : monitor
        bit   prev_stall = 1'b0;
        exp_t held = '0;
        exp_t got, e;
        forever begin
            @(negedge clk);
            got = {out_y, out_cb, out_cr, out_user};
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    total++;
                    if (!out_valid || got != held) begin
                        bad++;
                        $display("FAIL stall_hold: got v=%0b %h, want v=1 %h", out_valid, got, held);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_output: got y=%0d cb=%0d cr=%0d, want none",
                                 out_y, out_cb, out_cr);
                    end else begin
                        e = q.pop_front();
                        if (got != e) begin
                            bad++;
                            $display("FAIL pixel: got y=%0d cb=%0d cr=%0d u=%0d, want y=%0d cb=%0d cr=%0d u=%0d",
                                     out_y, out_cb, out_cr, out_user,
                                     e[3*W+U-1 -: W], e[2*W+U-1 -: W], e[W+U-1 -: W], e[U-1:0]);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                held = got;
            end
        end
    end

    task automatic drive(int r, int g, int b, bit st, logic [U-1:0] u);
        in_r = W'(r);
        in_g = W'(g);
        in_b = W'(b);
        in_studio = st;
        in_user = u;
        in_valid = 1'b1;
    endtask

    // Present one pixel, wait (bounded) for acceptance, return just after the accepting edge.
    task automatic send(int r, int g, int b, bit st, logic [U-1:0] u);
        int n = 0;
        drive(r, g, b, st, u);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, want 1", n);
        end else begin
            q.push_back(model(r, g, b, st, u));
        end
        @(posedge clk);
        #1;
    endtask

    // Single pixel into an idle pipeline with out_ready high: checks latency and fixed values.
    task automatic lat_check(string name, int r, int g, int b, bit st, int ey, int ecb, int ecr);
        int n;
        send(r, g, b, st, 2'd1);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, n, 4);
        check({name, "_y"}, int'(out_y), ey);
        check({name, "_cb"}, int'(out_cb), ecb);
        check({name, "_cr"}, int'(out_cr), ecr);
    endtask

    initial begin : main
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_outputs", int'({out_y, out_cb, out_cr, out_user}), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        lat_check("white_full", 255, 255, 255, 1'b0, 255, 128, 128);
        lat_check("black_full", 0, 0, 0, 1'b0, 0, 128, 128);
        lat_check("black_studio", 0, 0, 0, 1'b1, 16, 128, 128);
        lat_check("white_studio", 255, 255, 255, 1'b1, 235, 128, 128);
        lat_check("red_full", 255, 0, 0, 1'b0, 77, 85, 255);
        lat_check("blue_full", 0, 0, 255, 1'b0, 29, 255, 107);
        lat_check("red_studio", 255, 0, 0, 1'b1, 82, 90, 240);

        rand_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 1'(i % 2), U'($urandom_range(0, 3)));
        end
        in_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("stream_drained", q.size(), 0);

        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(255, 0, 0, 1'b0, 2'd3);
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        q.delete();
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_outputs", int'({out_y, out_cb, out_cr, out_user}), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        lat_check("post_reset_red", 255, 0, 0, 1'b0, 77, 85, 255);
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_no_stale", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
